// File: rtl/wbdownsizer.sv
// ============================================================================
// Module   : wbdownsizer
// Brief    : 128-bit pipelined Wishbone slave to 32-bit Wishbone master bridge.
//            Each wide request is split into one narrow beat per selected lane.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbdownsizer #(
    parameter  int AWIN  = 28,
    parameter  int DWIN  = 128,
    parameter  int DWOUT = 32,
    localparam int AWOUT = AWIN + 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    // wide slave side
    input  logic                 i_s_cyc,
    input  logic                 i_s_stb,
    input  logic                 i_s_we,
    input  logic [AWIN-1:0]      i_s_addr,
    input  logic [DWIN-1:0]      i_s_data,
    input  logic [DWIN/8-1:0]    i_s_sel,
    output logic                 o_s_ack,
    output logic                 o_s_stall,
    output logic [DWIN-1:0]      o_s_data,
    output logic                 o_s_err,
    // narrow master side
    output logic                 o_m_cyc,
    output logic                 o_m_stb,
    output logic                 o_m_we,
    output logic [AWOUT-1:0]     o_m_addr,
    output logic [DWOUT-1:0]     o_m_data,
    output logic [DWOUT/8-1:0]   o_m_sel,
    input  logic                 i_m_ack,
    input  logic                 i_m_stall,
    input  logic                 i_m_err,
    input  logic [DWOUT-1:0]     i_m_data
);

    localparam int c_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_we;
    logic [AWIN-1:0]       r_addr;
    logic [DWIN-1:0]       r_data;
    logic [DWIN/8-1:0]     r_sel;
    logic [c_LANES-1:0]    r_issue_mask;
    logic [c_LANES-1:0]    r_ack_mask;
    logic [DWIN-1:0]       r_s_data;
    logic                  r_s_ack;
    logic                  r_s_err;

    logic [c_LANES-1:0]    w_req_mask;
    logic                  w_accept;
    logic                  w_busy;
    logic                  w_abort;
    logic                  w_err;
    logic                  w_take;
    logic                  w_ack;
    logic                  w_done;
    logic [c_LANES-1:0]    w_issue_next;
    logic [c_LANES-1:0]    w_ack_next;
    logic [1:0]            w_iss_lane;
    logic [1:0]            w_ack_lane;
    logic [6:0]            w_iss_base;
    logic [3:0]            w_sel_base;
    logic [6:0]            w_ack_base;
    logic                  w_s_ack_next;
    logic                  w_s_err_next;

    // Mask bit n stands for lane n; lane 0 lives in the most significant slice.
    generate
        for (genvar g = 0; g < c_LANES; g++) begin : g_lane
            assign w_req_mask[g] = |i_s_sel[(c_LANES-1-g)*4 +: 4];
        end
    endgenerate

    function automatic logic [1:0] f_lowest(input logic [c_LANES-1:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_busy       = (r_state != S_IDLE);
    assign w_accept     = (r_state == S_IDLE) && i_s_cyc && i_s_stb;
    assign w_abort      = w_busy && !i_s_cyc;
    assign w_err        = w_busy && i_s_cyc && i_m_err;
    assign w_take       = (r_state == S_ISSUE) && !i_m_stall && (r_issue_mask != '0);
    assign w_ack        = w_busy && i_s_cyc && !i_m_err && i_m_ack && (r_ack_mask != '0);
    assign w_issue_next = w_take ? (r_issue_mask & (r_issue_mask - 4'd1)) : r_issue_mask;
    assign w_ack_next   = w_ack  ? (r_ack_mask & (r_ack_mask - 4'd1)) : r_ack_mask;
    assign w_done       = w_ack && (w_ack_next == '0);

    // Lane n maps to slice (3-n), and 3-n is simply ~n for a 2-bit index.
    assign w_iss_lane = f_lowest(r_issue_mask);
    assign w_ack_lane = f_lowest(r_ack_mask);
    assign w_iss_base = {~w_iss_lane, 5'b0};
    assign w_sel_base = {~w_iss_lane, 2'b0};
    assign w_ack_base = {~w_ack_lane, 5'b0};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_ack_next = 1'b0;
        w_s_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_mask != '0) begin
                        w_state_next = S_ISSUE;
                    end else begin
                        w_s_ack_next = 1'b1;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_err) begin
                    w_state_next = S_IDLE;
                    w_s_err_next = 1'b1;
                end else if (w_done) begin
                    w_state_next = S_IDLE;
                    w_s_ack_next = 1'b1;
                end else if ((r_state == S_ISSUE) && (w_issue_next == '0)) begin
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_sel        <= '0;
            r_issue_mask <= '0;
            r_ack_mask   <= '0;
            r_s_data     <= '0;
            r_s_ack      <= 1'b0;
            r_s_err      <= 1'b0;
        end else begin
            r_s_ack <= w_s_ack_next;
            r_s_err <= w_s_err_next;
            if (w_accept) begin
                r_we         <= i_s_we;
                r_addr       <= i_s_addr;
                r_data       <= i_s_data;
                r_sel        <= i_s_sel;
                r_issue_mask <= w_req_mask;
                r_ack_mask   <= w_req_mask;
                r_s_data     <= '0;
            end else if (w_abort || w_err) begin
                r_issue_mask <= '0;
                r_ack_mask   <= '0;
            end else begin
                r_issue_mask <= w_issue_next;
                r_ack_mask   <= w_ack_next;
                if (w_ack) begin
                    r_s_data[w_ack_base +: DWOUT] <= i_m_data;
                end
            end
        end
    end

    assign o_s_ack   = r_s_ack;
    assign o_s_err   = r_s_err;
    assign o_s_data  = r_s_data;
    assign o_s_stall = w_busy;
    assign o_m_cyc   = w_busy;
    assign o_m_stb   = (r_state == S_ISSUE);
    assign o_m_we    = r_we;
    assign o_m_addr  = {r_addr, w_iss_lane};
    assign o_m_data  = r_data[w_iss_base +: DWOUT];
    assign o_m_sel   = r_sel[w_sel_base +: 4];

endmodule

`default_nettype wire
